// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose: lets two requesters share one single-port data RAM. Port 0 is the
// CPU load/store path and port 1 is the debug/loader path. Each access walks
// IDLE -> ACCESS -> RESP, so one access takes three cycles.
//
// Optional feature (macro DMEM_ARB_ROUND_ROBIN_EN):
//   defined   : conflicts are resolved round-robin. The port that was not
//               granted most recently wins.
//   undefined : port 0 always wins a conflict. No pointer register exists.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req0/req1             access request per port (sampled only in IDLE)
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           byte address; word index = addr[ADDR_W+1:2]
//   wdata0/wdata1         write data
//   gnt0/gnt1             high for the ACCESS cycle of the winning port
//   done0/done1           high for the RESP cycle; rdata is valid for reads
//   err0/err1             high with doneN when the address was misaligned
//   rdata                 shared read data, held until the next read completes
//   ram_addr/ram_data     registered RAM address and write data (ACCESS only)
//   ram_wren/ram_rden     registered RAM strobes (ACCESS only)
//   ram_q                 RAM read data (RAM is clocked on ~clk)
//   busy                  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                port_q, port_d;
    logic                mis_q, mis_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;
    logic                ram_rden_q, ram_rden_d;

    // pick1 = 1 means port 1 wins this IDLE cycle.
    logic                pick1;
    logic                sel_we;
    logic [31:0]         sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_mis;

    // Only the word-index bits and the alignment bits of the address are used.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // rr_q = 1 means port 1 is preferred on the next conflict.
    // It flips on every grant to the port that did not get it.
    logic rr_q, rr_d;

    always_comb begin
        rr_d  = rr_q;
        pick1 = req1 && (!req0 || rr_q);
        if (state_q == IDLE && (req0 || req1)) begin
            rr_d = !pick1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is quiet.
    always_comb begin
        pick1 = req1 && !req0;
    end
`endif

    // Steer the winning port's request fields into the access registers.
    always_comb begin
        sel_we    = pick1 ? we1    : we0;
        sel_addr  = pick1 ? addr1  : addr0;
        sel_wdata = pick1 ? wdata1 : wdata0;
        sel_mis   = (sel_addr[1:0] != 2'b00);
    end

    // Next-state and output logic.
    // RAM strobes are loaded only on the IDLE->ACCESS edge, so they clear by
    // default in every other cycle. A misaligned access still takes a slot,
    // but it never strobes the RAM.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        mis_d      = mis_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rdata_d    = rdata_q;
        ram_addr_d = '0;
        ram_data_d = '0;
        ram_wren_d = 1'b0;
        ram_rden_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d    = ACCESS;
                    port_d     = pick1;
                    mis_d      = sel_mis;
                    gnt0_d     = !pick1;
                    gnt1_d     = pick1;
                    ram_addr_d = sel_addr[ADDR_W+1:2];
                    ram_data_d = sel_we ? sel_wdata : '0;
                    ram_wren_d = sel_we && !sel_mis;
                    ram_rden_d = !sel_we && !sel_mis;
                end
            end
            ACCESS: begin
                // The RAM fires on the falling edge of this cycle, so ram_q is
                // already settled at the rising edge that ends it.
                state_d = RESP;
                if (ram_rden_q) begin
                    rdata_d = ram_q;
                end
                done0_d = !port_q;
                done1_d = port_q;
                err0_d  = !port_q && mis_q;
                err1_d  = port_q && mis_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. When reset is sampled at the end of ACCESS,
    // the strobe for that cycle has already reached the RAM. Clearing the
    // registers here drops the done/err pulse that would otherwise follow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            port_q     <= 1'b0;
            mis_q      <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            ram_rden_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            mis_q      <= mis_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            ram_rden_q <= ram_rden_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign rdata    = rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_wren = ram_wren_q;
    assign ram_rden = ram_rden_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: RAM word-address width.
REQ-002 Parameter DATA_W, default 32: RAM data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0 / req1  in  1  access request, port 0 (CPU load/store) / port 1 (debug/loader).
REQ-006 we0 / we1  in  1  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0 / addr1  in  32  byte address; word index = addrN[ADDR_W+1:2].
REQ-008 wdata0 / wdata1  in  DATA_W  write data.
REQ-009 gnt0 / gnt1  out  1  one-cycle pulse: request accepted.
REQ-010 done0 / done1  out  1  one-cycle pulse: access complete; rdata valid for reads.
REQ-011 err0 / err1  out  1  pulse with doneN: misaligned address, access suppressed.
REQ-012 rdata  out  DATA_W  read data, shared by both ports.
REQ-013 ram_addr  out  ADDR_W; ram_data  out  DATA_W; ram_wren, ram_rden  out  1; ram_q  in  DATA_W.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; transitions: IDLE->ACCESS when req0|req1; ACCESS->RESP always; RESP->IDLE always.
REQ-016 reqN, weN, addrN and wdataN are sampled only in IDLE; the winner's values are registered on the IDLE->ACCESS edge.
REQ-017 gntN is high for exactly the ACCESS cycle of the winning port; the requester holds its signals until gnt and drops req in the following cycle unless it issues a new request.
REQ-018 ram_addr, ram_data, ram_wren and ram_rden are registered and driven only during ACCESS; all are 0 in every other state.
REQ-019 The RAM is clocked on ~clk; ram_q is valid at the rising edge ending ACCESS and is captured into rdata on that edge.
REQ-020 doneN pulses for the RESP cycle; rdata holds its value until the next read completes.
REQ-021 Latency: req asserted in IDLE at cycle N gives gnt at N+1, done at N+2, and the next acceptance no earlier than N+3.
REQ-022 A misaligned address (addrN[1:0] != 0) still passes through ACCESS, but ram_wren and ram_rden stay 0; errN pulses with doneN and rdata is unchanged.
REQ-023 When both ports request in IDLE, arbitration follows REQ-028/REQ-029; the loser is not latched and must keep req asserted.
REQ-024 Address bits above ADDR_W+1 are ignored, so the word index wraps modulo 2^ADDR_W.

Reset
REQ-025 On reset, the FSM enters IDLE; gnt, done, err, busy, ram_wren, ram_rden, ram_addr, ram_data and rdata clear to 0; the round-robin pointer is set so that port 0 wins the first conflict.
REQ-026 Reset sampled during ACCESS does not retract that cycle's RAM strobe (a write already presented commits); no done or err pulse follows.
REQ-027 Reset dominates any simultaneous request: no grant issues in the reset cycle.

Configuration
REQ-028 With DMEM_ARB_ROUND_ROBIN_EN defined, on a conflict the port not served by the most recent completed access wins; the pointer updates on each grant.
REQ-029 Without DMEM_ARB_ROUND_ROBIN_EN, port 0 always wins conflicts and no pointer register exists.

Verification
REQ-030 req0=1, we0=1, addr0=0x10, wdata0=0xDEADBEEF, then a port-0 read of 0x10 -> second access: done0 pulses with rdata=0xDEADBEEF, ram_addr=4 during both ACCESS cycles.
REQ-031 req0 and req1 both held high for two accesses with round-robin enabled -> gnt0 first, then gnt1; with the macro off -> gnt0 twice.
REQ-032 Port-1 write to addr1=0x13 -> err1 and done1 pulse together, ram_wren stays 0, and a later read of word 4 returns the old value.
REQ-033 Reset asserted in the ACCESS cycle of a write of 0x12345678 to 0x20 -> no done0 pulse, FSM in IDLE, and a subsequent read of 0x20 returns 0x12345678.
REQ-034 Back-to-back port-0 reads issued at cycle 0 -> gnt0 at cycles 1 and 4, done0 at cycles 2 and 5, busy low only at cycles 0 and 3.
